tcam_lookup_arbiter: RTL and testbench

Shares the single-port TCAM memory wrapper between NUM_REQ lookup requesters and one configuration port. Grants one operation at a time and drives the wrapper's MODE/data/address inputs. Sequences the two-cycle compare (COMPARE then forced CMP_RD), samples the wrapper's DstID output after a fixed delay, and returns it to the winning requester over a valid/ready response channel. Sits between the packet-routing front end and the TCAM memory wrapper.

---
 rtl/tcam_arb_pkg.sv | 20 ++
 rtl/tcam_lookup_arbiter_rr_arbiter.sv | 31 +++
 rtl/tcam_lookup_arbiter.sv | 152 +++++++++++++++
 tb/tb_tcam_lookup_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_arb_pkg.sv
// Shared constants for the TCAM lookup arbiter: wrapper MODE codes, config ops and FSM states.
package tcam_arb_pkg;

    localparam logic [2:0] MODE_I = 3'b000;
    localparam logic [2:0] MODE_W = 3'b001;
    localparam logic [2:0] MODE_R = 3'b010;
    localparam logic [2:0] MODE_F = 3'b011;
    localparam logic [2:0] MODE_C = 3'b100;

    localparam logic CFG_WR  = 1'b0;
    localparam logic CFG_FLU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CFG  = 2'd1,
        S_CMP  = 2'd2,
        S_RSP  = 2'd3
    } state_t;

endpackage

// File: rtl/tcam_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_pick;

    // Prefer requesters at/above the pointer; fall back to the lowest valid one.
    assign w_mask  = ~((NUM_REQ'(1) << i_ptr) - NUM_REQ'(1));
    assign w_hi    = i_valid & w_mask;
    assign w_pick  = (|w_hi) ? w_hi : i_valid;
    assign o_grant = w_pick & (~w_pick + NUM_REQ'(1));
    assign o_any   = |i_valid;

    always_comb begin
        o_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_grant[k]) o_idx = IDX_W'(k);
        end
    end

endmodule

// File: rtl/tcam_lookup_arbiter.sv
// Arbitrates one config port and NUM_REQ lookup requesters onto a single-port TCAM wrapper.
//   state  | meaning
//   S_IDLE | free: accept config (priority) or grant one lookup
//   S_CFG  | W/F issued last edge, one I cycle before next operation
//   S_CMP  | compare in flight, counting until mem_dst is sampled
//   S_RSP  | response held until rsp_ready
module tcam_lookup_arbiter
    import tcam_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int ID_Width    = 4,
    parameter  int AddressSize = 4,
    parameter  int Bits        = 8,
    parameter  int RSP_DLY     = 4,
    localparam int REQ_W       = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           lk_valid,
    output logic [NUM_REQ-1:0]           lk_ready,
    input  logic [NUM_REQ*ID_Width-1:0]  lk_pid,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [REQ_W-1:0]             rsp_req,
    output logic [ID_Width-1:0]          rsp_dst,
    output logic                         rsp_hit,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         cfg_op,
    input  logic [AddressSize-1:0]       cfg_addr,
    input  logic [Bits-1:0]              cfg_data,
    input  logic [Bits-1:0]              cfg_mskb,
    input  logic                         cfg_vbe,
    input  logic                         cfg_dcs,
    input  logic                         cfg_vbi,
    output logic [2:0]                   mem_mode,
    output logic [ID_Width-1:0]          mem_pid,
    output logic [Bits-1:0]              mem_data,
    output logic [Bits-1:0]              mem_mskb,
    output logic [AddressSize-1:0]       mem_addr,
    output logic                         mem_vbe,
    output logic                         mem_dcs,
    output logic                         mem_vbi,
    input  logic [ID_Width-1:0]          mem_dst
);

    localparam int CNT_W = $clog2(RSP_DLY + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [REQ_W-1:0]   r_ptr;
    logic [REQ_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] w_gnt;
    logic [REQ_W-1:0]   w_gnt_idx;
    logic               w_any;
    logic               w_cfg_take;
    logic               w_lk_take;
    logic               w_sample;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_valid (lk_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_any   (w_any)
    );

    assign w_sample = (r_state == S_CMP) && (r_cnt == CNT_W'(RSP_DLY - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid)  w_state_nxt = S_CFG;
                else if (w_any) w_state_nxt = S_CMP;
            end
            S_CFG:   w_state_nxt = S_IDLE;
            S_CMP:   if (w_sample)  w_state_nxt = S_RSP;
            S_RSP:   if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready  = 1'b0;
        lk_ready   = '0;
        w_cfg_take = 1'b0;
        w_lk_take  = 1'b0;
        if (r_state == S_IDLE) begin
            if (cfg_valid) begin
                cfg_ready  = 1'b1;
                w_cfg_take = 1'b1;
            end else if (w_any) begin
                lk_ready  = w_gnt;
                w_lk_take = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_mode  <= MODE_I;
            mem_pid   <= '0;
            mem_data  <= '0;
            mem_mskb  <= '0;
            mem_addr  <= '0;
            mem_vbe   <= 1'b0;
            mem_dcs   <= 1'b0;
            mem_vbi   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_req   <= '0;
            rsp_dst   <= '0;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
        end else begin
            mem_mode <= MODE_I;
            if (w_cfg_take) begin
                mem_mode <= (cfg_op == CFG_FLU) ? MODE_F : MODE_W;
                mem_addr <= cfg_addr;
                mem_data <= cfg_data;
                mem_mskb <= cfg_mskb;
                mem_vbe  <= cfg_vbe;
                mem_dcs  <= cfg_dcs;
                mem_vbi  <= cfg_vbi;
            end else if (w_lk_take) begin
                mem_mode <= MODE_C;
                mem_pid  <= lk_pid[w_gnt_idx*ID_Width +: ID_Width];
                r_owner  <= w_gnt_idx;
                r_ptr    <= (w_gnt_idx == REQ_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + REQ_W'(1);
                r_cnt    <= CNT_W'(1);
            end
            // The wrapper's forced CMP_RD cycle rides on MODE_I; only the counter moves here.
            if (r_state == S_CMP) r_cnt <= r_cnt + CNT_W'(1);
            if (w_sample) begin
                rsp_valid <= 1'b1;
                rsp_req   <= r_owner;
                rsp_dst   <= mem_dst;
            end
            if ((r_state == S_RSP) && rsp_ready) rsp_valid <= 1'b0;
        end
    end

    assign rsp_hit = |rsp_dst;

endmodule

// File: tb/tb_tcam_lookup_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter plus directed and random traffic.
module tb_tcam_lookup_arbiter;

    localparam int N   = 4;
    localparam int IW  = 4;
    localparam int AW  = 4;
    localparam int BW  = 8;
    localparam int DLY = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    lk_valid;
    logic [N-1:0]    lk_ready;
    logic [N*IW-1:0] lk_pid;
    logic            rsp_valid, rsp_ready, rsp_hit;
    logic [1:0]      rsp_req;
    logic [IW-1:0]   rsp_dst;
    logic            cfg_valid, cfg_ready, cfg_op;
    logic [AW-1:0]   cfg_addr;
    logic [BW-1:0]   cfg_data, cfg_mskb;
    logic            cfg_vbe, cfg_dcs, cfg_vbi;
    logic [2:0]      mem_mode;
    logic [IW-1:0]   mem_pid;
    logic [BW-1:0]   mem_data, mem_mskb;
    logic [AW-1:0]   mem_addr;
    logic            mem_vbe, mem_dcs, mem_vbi;
    logic [IW-1:0]   mem_dst;

    tcam_lookup_arbiter #(
        .NUM_REQ(N), .ID_Width(IW), .AddressSize(AW), .Bits(BW), .RSP_DLY(DLY)
    ) dut (
        .clk(clk), .rst(rst),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_pid(lk_pid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_req(rsp_req),
        .rsp_dst(rsp_dst), .rsp_hit(rsp_hit),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mskb(cfg_mskb),
        .cfg_vbe(cfg_vbe), .cfg_dcs(cfg_dcs), .cfg_vbi(cfg_vbi),
        .mem_mode(mem_mode), .mem_pid(mem_pid), .mem_data(mem_data),
        .mem_mskb(mem_mskb), .mem_addr(mem_addr),
        .mem_vbe(mem_vbe), .mem_dcs(mem_dcs), .mem_vbi(mem_vbi),
        .mem_dst(mem_dst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: "busy" flags and timestamps rather than a state encoding.
    logic          m_busy_cmp, m_cool, m_rspv;
    int            m_gcyc, m_owner, m_ptr;
    logic [IW-1:0] m_pid;
    logic [2:0]    e_mode;
    logic [IW-1:0] e_pid, e_dst;
    logic [BW-1:0] e_data, e_mskb;
    logic [AW-1:0] e_addr;
    logic          e_vbe, e_dcs, e_vbi;
    int            e_req;
    logic [N-1:0]  e_lkr;
    logic          e_cfgr;
    logic [IW-1:0] lut [16];
    logic [N-1:0]  s_lkr;
    logic          s_cfgr;
    int            last_gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        if (rst) begin
            m_busy_cmp = 0; m_cool = 0; m_rspv = 0; m_ptr = 0;
            e_mode = 3'b000; e_pid = '0; e_data = '0; e_mskb = '0; e_addr = '0;
            e_vbe = 0; e_dcs = 0; e_vbi = 0; e_req = 0; e_dst = '0;
        end else if (m_rspv) begin
            e_mode = 3'b000;
            if (rsp_ready) m_rspv = 0;
        end else if (m_busy_cmp) begin
            e_mode = 3'b000;
            if (cyc == m_gcyc + DLY - 1) begin
                m_rspv = 1; e_req = m_owner; e_dst = mem_dst; m_busy_cmp = 0;
            end
        end else if (m_cool) begin
            e_mode = 3'b000; m_cool = 0;
        end else if (cfg_valid) begin
            e_mode = cfg_op ? 3'b011 : 3'b001;
            e_addr = cfg_addr; e_data = cfg_data; e_mskb = cfg_mskb;
            e_vbe = cfg_vbe; e_dcs = cfg_dcs; e_vbi = cfg_vbi;
            m_cool = 1;
        end else if (lk_valid != 0) begin
            g = rr_pick(lk_valid, m_ptr);
            e_mode = 3'b100; e_pid = lk_pid[g*IW +: IW]; m_pid = e_pid;
            m_owner = g; m_ptr = (g + 1) % N; m_busy_cmp = 1; m_gcyc = cyc;
        end else begin
            e_mode = 3'b000;
        end
    endtask

    // One clock: comb checks before the edge, model update at the edge, register checks after.
    task automatic cycle();
        int g;
        if (m_busy_cmp && (cyc == m_gcyc + DLY - 1)) mem_dst = lut[m_pid];
        else mem_dst = IW'($urandom);
        #1;
        e_cfgr = (!m_busy_cmp && !m_cool && !m_rspv) && cfg_valid;
        e_lkr  = '0;
        if (!m_busy_cmp && !m_cool && !m_rspv && !cfg_valid && lk_valid != 0) begin
            g = rr_pick(lk_valid, m_ptr);
            e_lkr[g] = 1'b1;
        end
        s_lkr = lk_ready; s_cfgr = cfg_ready;
        last_gnt = -1;
        for (int k = 0; k < N; k++) if (lk_ready[k]) last_gnt = k;
        if (!rst) begin
            chk("lk_ready", 32'(lk_ready), 32'(e_lkr));
            chk("cfg_ready", 32'(cfg_ready), 32'(e_cfgr));
        end
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (!rst) begin
            for (int k = 0; k < N; k++) if (lk_valid[k] && e_lkr[k]) lk_valid[k] = 1'b0;
            if (cfg_valid && e_cfgr) cfg_valid = 1'b0;
        end
        chk("mem_mode", 32'(mem_mode), 32'(e_mode));
        chk("mem_pid", 32'(mem_pid), 32'(e_pid));
        chk("mem_cfg", {mem_addr, mem_data, mem_mskb, mem_vbe, mem_dcs, mem_vbi},
                       {e_addr, e_data, e_mskb, e_vbe, e_dcs, e_vbi});
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rspv));
        chk("rsp_req", 32'(rsp_req), 32'(e_req));
        chk("rsp_dst", 32'(rsp_dst), 32'(e_dst));
        chk("rsp_hit", 32'(rsp_hit), 32'(e_dst != 0));
        @(negedge clk);
    endtask

    task automatic do_reset();
        lk_valid = '0; cfg_valid = 0; rsp_ready = 0; rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic set_pid(input int i, input logic [IW-1:0] p);
        lk_pid[i*IW +: IW] = p;
    endtask

    int q[$];
    int n;

    initial begin
        rst = 1; lk_valid = '0; lk_pid = '0; rsp_ready = 0;
        cfg_valid = 0; cfg_op = 0; cfg_addr = '0; cfg_data = '0; cfg_mskb = '0;
        cfg_vbe = 0; cfg_dcs = 0; cfg_vbi = 0; mem_dst = '0;
        m_busy_cmp = 0; m_cool = 0; m_rspv = 0; m_ptr = 0; m_gcyc = 0; m_owner = 0; m_pid = '0;
        for (int k = 0; k < 16; k++) lut[k] = ($urandom_range(3) == 0) ? '0 : IW'($urandom);
        lut[4'hA] = 4'h7; lut[4'h3] = 4'h0; lut[4'h5] = 4'hC;
        @(negedge clk);
        do_reset();
        chk("reset_mode", 32'(mem_mode), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);

        // Config write
        cfg_valid = 1; cfg_op = 0; cfg_addr = 4'd3; cfg_data = 8'h5A; cfg_mskb = 8'hFF;
        cfg_vbe = 1; cfg_dcs = 1; cfg_vbi = 1;
        cycle();
        chk("cfgw_ready", 32'(s_cfgr), 32'h1);
        chk("cfgw_mode", 32'(mem_mode), 32'h1);
        chk("cfgw_fields", {mem_addr, mem_data, mem_mskb, mem_vbe, mem_dcs, mem_vbi},
                           {4'd3, 8'h5A, 8'hFF, 1'b1, 1'b1, 1'b1});
        cycle();
        chk("cfgw_ready_pulse", 32'(s_cfgr), 32'h0);
        chk("cfgw_mode_after", 32'(mem_mode), 32'h0);

        // Lookup from requester 2
        set_pid(2, 4'hA); lk_valid = 4'b0100;
        cycle();
        chk("lk2_grant", 32'(s_lkr), 32'h4);
        chk("lk2_mode", 32'(mem_mode), 32'h4);
        chk("lk2_pid", 32'(mem_pid), 32'hA);
        for (int k = 1; k < DLY; k++) begin
            cycle();
            chk("lk2_latency", 32'(rsp_valid), 32'(k == DLY - 1));
        end
        chk("lk2_req", 32'(rsp_req), 32'h2);
        chk("lk2_dst", 32'(rsp_dst), 32'h7);
        chk("lk2_hit", 32'(rsp_hit), 32'h1);
        rsp_ready = 1;
        cycle();

        // Round-robin with all requesters continuously valid
        do_reset();
        rsp_ready = 1;
        for (int k = 0; k < N; k++) set_pid(k, IW'(k + 4));
        n = 0;
        while (q.size() < 5 && n < 200) begin
            lk_valid = '1;
            cycle();
            if (last_gnt >= 0) q.push_back(last_gnt);
            n++;
        end
        chk("rr_count", 32'(q.size()), 32'd5);
        for (int k = 0; k < q.size(); k++) chk("rr_order", 32'(q[k]), 32'(k % N));

        // Config beats a simultaneous lookup; response held under back-pressure
        do_reset();
        lk_valid = '0;
        cfg_valid = 1; cfg_op = 0; cfg_addr = 4'd9; cfg_data = 8'h33; cfg_mskb = 8'h0F;
        cfg_vbe = 0; cfg_dcs = 1; cfg_vbi = 0;
        set_pid(0, 4'h5); lk_valid[0] = 1; rsp_ready = 0;
        cycle();
        chk("prio_cfg", 32'(s_cfgr), 32'h1);
        chk("prio_lk_blocked", 32'(s_lkr), 32'h0);
        cycle();
        chk("prio_lk_wait", 32'(s_lkr), 32'h0);
        cycle();
        chk("prio_lk_next", 32'(s_lkr), 32'h1);
        set_pid(1, 4'hA); lk_valid[1] = 1;
        n = 0;
        while (!rsp_valid && n < 20) begin cycle(); n++; end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'h1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold_dst", 32'(rsp_dst), 32'hC);
            chk("bp_no_grant", 32'(mem_mode), 32'h0);
        end
        rsp_ready = 1;
        cycle();

        // Miss and flush
        do_reset();
        rsp_ready = 1; set_pid(1, 4'h3); lk_valid = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 20) begin cycle(); n++; end
        chk("miss_valid", 32'(rsp_valid), 32'h1);
        chk("miss_dst", 32'(rsp_dst), 32'h0);
        chk("miss_hit", 32'(rsp_hit), 32'h0);
        cycle();
        cfg_valid = 1; cfg_op = 1;
        cycle();
        chk("flush_mode", 32'(mem_mode), 32'h3);
        cycle();
        chk("flush_mode_after", 32'(mem_mode), 32'h0);

        // Reset in the middle of a compare
        do_reset();
        set_pid(0, 4'hA); lk_valid = 4'b0001;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        chk("rstcmp_mode", 32'(mem_mode), 32'h0);
        chk("rstcmp_rsp", 32'(rsp_valid), 32'h0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rstcmp_no_rsp", 32'(rsp_valid), 32'h0);
        end
        set_pid(3, 4'hA); lk_valid = 4'b1000;
        for (int k = 0; k < DLY; k++) cycle();
        chk("rstcmp_fresh_valid", 32'(rsp_valid), 32'h1);
        chk("rstcmp_fresh_req", 32'(rsp_req), 32'h3);
        chk("rstcmp_fresh_dst", 32'(rsp_dst), 32'h7);
        rsp_ready = 1;
        cycle();

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!lk_valid[i] && $urandom_range(99) < 25) begin
                    lk_valid[i] = 1'b1;
                    set_pid(i, IW'($urandom));
                end
            end
            if (!cfg_valid && $urandom_range(99) < 5) begin
                cfg_valid = 1; cfg_op = 1'($urandom); cfg_addr = AW'($urandom);
                cfg_data = BW'($urandom); cfg_mskb = BW'($urandom);
                cfg_vbe = 1'($urandom); cfg_dcs = 1'($urandom); cfg_vbi = 1'($urandom);
            end
            rsp_ready = ($urandom_range(99) < 60);
            rst = ($urandom_range(999) < 5);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
